// File: rtl/tmds_pkg.sv
// tmds_pkg: shared FSM state, phase count and TMDS control tokens for the load sequencer.
package tmds_pkg;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  localparam int TMDS_PHASES = 10;
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;
  function automatic logic [3:0] phase_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= 5'(TMDS_PHASES) ? 4'(s - 5'(TMDS_PHASES)) : s[3:0];
  endfunction
endpackage

// File: rtl/pix_edge_sync.sv
// pix_edge_sync: brings the pixel-domain toggle across with two flops and turns each inversion into a one-cycle pulse.
module pix_edge_sync (
  input  logic clk_pixel_x10,
  input  logic reset,
  input  logic toggle,
  output logic pulse
);
  (* async_reg = "true" *) logic s1;
  (* async_reg = "true" *) logic s2;
  logic s3;
  always_ff @(posedge clk_pixel_x10)
    if (reset) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {toggle, s1, s2};
  assign pulse = s2 ^ s3;
endmodule

// File: rtl/tmds_load_sequencer.sv
// tmds_load_sequencer: locks a mod-10 phase counter to the pixel toggle and feeds the 10:1 serializer.
// Define TMDS_BITSLIP_EN to add the slip input that rotates the load/capture phases while locked.
module tmds_load_sequencer
  import tmds_pkg::*;
#(
  parameter int LOAD_PHASE    = 9,
  parameter int CAPTURE_PHASE = 4,
  parameter int LOCK_COUNT    = 16,
  parameter int MISS_LIMIT    = 4
) (
  input  logic       clk_pixel_x10,
  input  logic       reset,
  input  logic       pix_toggle,
`ifdef TMDS_BITSLIP_EN
  input  logic       slip,
`endif
  input  logic [9:0] word_in0,
  input  logic [9:0] word_in1,
  input  logic [9:0] word_in2,
  output logic       load,
  output logic [9:0] word_out0,
  output logic [9:0] word_out1,
  output logic [9:0] word_out2,
  output logic       locked,
  output logic [3:0] phase
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  state_t state, state_n;
  logic [GW-1:0] good_cnt;
  logic [MW-1:0] miss_cnt;
  logic [9:0] hold0, hold1, hold2;
  logic [3:0] off, load_ph, cap_ph;
  logic pix_edge, edge_ok, miss;
  pix_edge_sync u_sync (
    .clk_pixel_x10(clk_pixel_x10),
    .reset(reset),
    .toggle(pix_toggle),
    .pulse(pix_edge)
  );
`ifdef TMDS_BITSLIP_EN
  always_ff @(posedge clk_pixel_x10)
    if (reset) off <= '0;
    else if (slip && state == LOCKED) off <= off == 4'd9 ? 4'd0 : off + 4'd1;
`else
  assign off = 4'd0;
`endif
  assign load_ph = phase_add(4'(LOAD_PHASE), off);
  assign cap_ph  = phase_add(4'(CAPTURE_PHASE), off);
  assign edge_ok = pix_edge && phase == 4'd9;
  assign miss    = pix_edge != (phase == 4'd9);
  assign locked  = state == LOCKED;
  always_comb begin
    state_n = state;
    case (state)
      SEARCH:  state_n = pix_edge ? VERIFY : SEARCH;
      VERIFY:  state_n = miss ? SEARCH : (edge_ok && good_cnt == GW'(LOCK_COUNT - 1)) ? LOCKED : VERIFY;
      LOCKED:  state_n = (miss && miss_cnt == MW'(MISS_LIMIT - 1)) ? SEARCH : LOCKED;
      default: state_n = SEARCH;
    endcase
  end
  always_ff @(posedge clk_pixel_x10) begin
    if (reset) begin
      state     <= SEARCH;
      phase     <= '0;
      good_cnt  <= '0;
      miss_cnt  <= '0;
      load      <= 1'b0;
      hold0     <= CTRL_TOKEN_00;
      hold1     <= CTRL_TOKEN_00;
      hold2     <= CTRL_TOKEN_00;
      word_out0 <= CTRL_TOKEN_00;
      word_out1 <= CTRL_TOKEN_00;
      word_out2 <= CTRL_TOKEN_00;
    end else begin
      state    <= state_n;
      phase    <= (state == SEARCH && pix_edge) || phase == 4'd9 ? 4'd0 : phase + 4'd1;
      good_cnt <= state != VERIFY ? '0 : (edge_ok && good_cnt != '1) ? good_cnt + GW'(1) : good_cnt;
      miss_cnt <= (state != LOCKED || edge_ok) ? '0 : (miss && miss_cnt != '1) ? miss_cnt + MW'(1) : miss_cnt;
      load     <= phase == load_ph;
      if (phase == cap_ph) begin
        hold0 <= word_in0;
        hold1 <= word_in1;
        hold2 <= word_in2;
      end
      // Output words change on the same edge that raises load, so they are valid during the load cycle.
      if (phase == load_ph) begin
        word_out0 <= locked ? hold0 : CTRL_TOKEN_00;
        word_out1 <= locked ? hold1 : CTRL_TOKEN_00;
        word_out2 <= locked ? hold2 : CTRL_TOKEN_00;
      end
    end
  end
endmodule

// File: tb/tb_tmds_load_sequencer.sv
// tb_tmds_load_sequencer: scoreboard bench for lock acquisition, drift, glitch, reset and optional slip.
module tb_tmds_load_sequencer;
  import tmds_pkg::*;
  logic clk_pixel_x10 = 1'b0;
  logic reset = 1'b1;
  logic pix_toggle = 1'b0;
`ifdef TMDS_BITSLIP_EN
  logic slip = 1'b0;
`endif
  logic [9:0] word_in0 = '0, word_in1 = '0, word_in2 = '0;
  logic load, locked;
  logic [9:0] word_out0, word_out1, word_out2;
  logic [3:0] phase;
  int errors = 0, checks = 0, cyc = 0, pix_next = 0, t = 0, c0 = 0;
  bit pix_en = 1'b0;
  logic [29:0] exp_q[$];

  always #5 clk_pixel_x10 = ~clk_pixel_x10;

  tmds_load_sequencer dut (
    .clk_pixel_x10(clk_pixel_x10),
    .reset(reset),
    .pix_toggle(pix_toggle),
`ifdef TMDS_BITSLIP_EN
    .slip(slip),
`endif
    .word_in0(word_in0),
    .word_in1(word_in1),
    .word_in2(word_in2),
    .load(load),
    .word_out0(word_out0),
    .word_out1(word_out1),
    .word_out2(word_out2),
    .locked(locked),
    .phase(phase)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock; the pixel-domain toggle generator runs here so it never drifts from the bench's cycle count.
  task automatic step();
    @(posedge clk_pixel_x10);
    #1;
    cyc++;
    if (pix_en && cyc == pix_next) begin
      pix_toggle = ~pix_toggle;
      pix_next += 10;
    end
  endtask

  task automatic step_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_load();
    int n = 0;
    do begin
      step();
      n++;
    end while (!load && n < 30);
    if (!load) check("load_timeout", 32'(load), 32'(1));
  endtask

  task automatic send(input string tag, input logic [9:0] w0, w1, w2, input bit lk);
    word_in0 = w0;
    word_in1 = w1;
    word_in2 = w2;
    exp_q.push_back(lk ? {w0, w1, w2} : {3{CTRL_TOKEN_00}});
    wait_load();
    wait_load();
    check(tag, 32'({word_out0, word_out1, word_out2}), 32'(exp_q.pop_front()));
  endtask

  task automatic check_load_phase(input string tag, input logic [3:0] exp_ph, input int n);
    int prev;
    wait_load();
    for (int i = 0; i < n; i++) begin
      prev = cyc;
      wait_load();
      check({tag, "_period"}, 32'(cyc - prev), 32'(10));
      check({tag, "_phase"}, 32'(phase), 32'(exp_ph));
    end
  endtask

`ifdef TMDS_BITSLIP_EN
  task automatic pulse_slip(input int n);
    for (int i = 0; i < n; i++) begin
      slip = 1'b1;
      step();
      slip = 1'b0;
      step();
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("rst_phase", 32'(phase), 32'(0));
    check("rst_load", 32'(load), 32'(0));
    check("rst_locked", 32'(locked), 32'(0));
    check("rst_words", 32'({word_out0, word_out1, word_out2}), 32'({3{CTRL_TOKEN_00}}));
    reset = 1'b0;
    send("prelock_words", 10'h155, 10'h155, 10'h155, 1'b0);
    // Toggle k is seen three clocks later; the 17th edge (1 to align + 16 aligned) locks.
    pix_en = 1'b1;
    pix_next = cyc + 1;
    c0 = pix_next;
    step_until(c0 + 162);
    check("lock_before", 32'(locked), 32'(0));
    step();
    check("lock_after", 32'(locked), 32'(1));
    send("locked_words", 10'h2AA, 10'h3CC, 10'h0F0, 1'b1);
    check_load_phase("lock", 4'd0, 3);
    // Glitch: one toggle 3 clocks early, then back on schedule.
    step_until(pix_next);
    t = cyc;
    pix_next = t + 7;
    step_until(t + 7);
    pix_next = t + 20;
    step_until(t + 13);
    check("glitch_miss2", 32'(dut.miss_cnt), 32'(2));
    check("glitch_locked", 32'(locked), 32'(1));
    step_until(t + 23);
    check("glitch_miss0", 32'(dut.miss_cnt), 32'(0));
    check("glitch_still_locked", 32'(locked), 32'(1));
    // Drift: permanent 3-clock shift costs two misses per pixel period.
    step_until(pix_next);
    t = cyc;
    pix_next = t + 13;
    step_until(t + 25);
    check("drift_locked", 32'(locked), 32'(1));
    step();
    check("drift_unlocked", 32'(locked), 32'(0));
    send("unlocked_words", 10'h1FF, 10'h200, 10'h0AA, 1'b0);
`ifdef TMDS_BITSLIP_EN
    pulse_slip(1);
`endif
    step_until(t + 195);
    check("relock_before", 32'(locked), 32'(0));
    step();
    check("relock_after", 32'(locked), 32'(1));
    check_load_phase("relock", 4'd0, 2);
    send("relock_words", 10'h111, 10'h222, 10'h333, 1'b1);
`ifdef TMDS_BITSLIP_EN
    pulse_slip(3);
    check_load_phase("slip3", 4'd3, 2);
    send("slip_words", 10'h0C3, 10'h30C, 10'h2D2, 1'b1);
    pulse_slip(7);
    check_load_phase("slip10", 4'd0, 2);
`endif
    begin
      int n = 0;
      while (phase != 4'd5 && n < 20) begin
        step();
        n++;
      end
      check("find_phase5", 32'(phase), 32'(5));
    end
    reset = 1'b1;
    step();
    check("midrst_phase", 32'(phase), 32'(0));
    check("midrst_locked", 32'(locked), 32'(0));
    check("midrst_load", 32'(load), 32'(0));
    check("midrst_words", 32'({word_out0, word_out1, word_out2}), 32'({3{CTRL_TOKEN_00}}));
    reset = 1'b0;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
